// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the oversample rate.
package uart_pkg;

  localparam int OS_RATE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-data/status pulses of the UART receiver.
interface uart_rx_if #(parameter int NBIT_DATA_LEN = 8);
  logic                     rx;
  logic [NBIT_DATA_LEN-1:0] rx_data_out;
  logic                     rx_done_tick;
  logic                     frame_err_tick;
  logic                     parity_err_tick;

  modport master (output rx, input rx_data_out, rx_done_tick, frame_err_tick, parity_err_tick);
  modport slave  (input rx, output rx_data_out, rx_done_tick, frame_err_tick, parity_err_tick);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-clk s_tick every CLK_DIV clk cycles.
module uart_baud_gen #(
  parameter int CLK_DIV = 163
) (
  input  logic clk,
  input  logic reset_n,
  output logic s_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      s_tick <= 1'b0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt    <= '0;
      s_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      s_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first. Define UART_RX_PARITY_EN for an even-parity bit.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | qualifying the start bit at its midpoint
// DATA      | sampling data bits at mid-bit
// PARITY    | sampling the parity bit (parity builds only)
// STOP      | sampling the stop bit, reporting the frame
// WAIT_HIGH | low stop bit seen, waiting out a break
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBIT_DATA_LEN = 8,
  parameter int SB_TICK       = 16,
  parameter int CLK_DIV       = 163
) (
  input logic       clk,
  input logic       reset_n,
  uart_rx_if.slave  bus
);
  localparam int SW = $clog2((SB_TICK > OS_RATE) ? SB_TICK : OS_RATE);
  localparam int NW = $clog2(NBIT_DATA_LEN + 1);

  uart_state_e              state, state_n;
  logic [SW-1:0]            s_cnt, s_cnt_n;
  logic [NW-1:0]            n_cnt, n_cnt_n;
  logic [NBIT_DATA_LEN-1:0] b_reg, b_n;
  logic                     rx_s1, rx_s;
  logic                     s_tick;
  logic                     done_n, ferr_n, perr_n;
  logic                     par_err;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .s_tick  (s_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s  <= rx_s1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      par_err <= 1'b0;
    else if (state == PARITY && s_tick && s_cnt == SW'(OS_RATE - 1))
      par_err <= (^b_reg) ^ rx_s;
  end
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      s_cnt                <= '0;
      n_cnt                <= '0;
      b_reg                <= '0;
      bus.rx_data_out      <= '0;
      bus.rx_done_tick     <= 1'b0;
      bus.frame_err_tick   <= 1'b0;
      bus.parity_err_tick  <= 1'b0;
    end else begin
      state                <= state_n;
      s_cnt                <= s_cnt_n;
      n_cnt                <= n_cnt_n;
      b_reg                <= b_n;
      bus.rx_done_tick     <= done_n;
      bus.frame_err_tick   <= ferr_n;
      bus.parity_err_tick  <= perr_n;
      if (done_n)
        bus.rx_data_out <= b_reg;
    end
  end

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    b_n     = b_reg;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          s_cnt_n = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == SW'(7)) begin
            s_cnt_n = '0;
            n_cnt_n = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == SW'(OS_RATE - 1)) begin
            s_cnt_n = '0;
            b_n     = {rx_s, b_reg[NBIT_DATA_LEN-1:1]};
            if (n_cnt == NW'(NBIT_DATA_LEN - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_cnt_n = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt == SW'(OS_RATE - 1)) begin
            s_cnt_n = '0;
            state_n = STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SW'(SB_TICK - 1)) begin
            s_cnt_n = '0;
            if (rx_s) begin
              done_n  = !par_err;
              perr_n  = par_err;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
